spi_reg_bank: RTL and testbench

- Register bank directly downstream of the SPI slave driver.
- Consumes the driver's write strobe/address/data and its read-enable burst, and returns read data into the driver's read FIFO.
- Holds the control registers seen by the rest of the PMT logic, samples status inputs, and implements a sticky, maskable interrupt register.
- Addresses are byte addresses with a 4-byte word stride, matching the driver's +4 auto-increment.

---
 rtl/spi_reg_bank_if.sv | 23 ++
 rtl/spi_reg_bank.sv | 171 +++++++++++++++++
 tb/tb_spi_reg_bank.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bank_if.sv
// Bus between the SPI slave driver (master side) and the register bank (slave side).
// Carries the write strobe/address/data, the read-enable burst and the returned read data.
interface spi_reg_bank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                  slave_wr_en;
   logic [ADDR_WIDTH-1:0] slave_addr;
   logic [DATA_WIDTH-1:0] slave_wr_data;
   logic                  slave_rd_en;
   logic                  slave_rd_vld;
   logic [DATA_WIDTH-1:0] slave_rd_data;

   modport master (
      output slave_wr_en, slave_addr, slave_wr_data, slave_rd_en,
      input  slave_rd_vld, slave_rd_data
   );

   modport slave (
      input  slave_wr_en, slave_addr, slave_wr_data, slave_rd_en,
      output slave_rd_vld, slave_rd_data
   );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI register bank: RW control registers, RO status words, sticky maskable IRQ, 2-cycle read pipe.
// Define SPI_REG_WDT_EN to build the inactivity watchdog that clears the control registers.
module spi_reg_bank #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    REG_NUM    = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    WDT_CYCLES = 100_000_000
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   spi_reg_bank_if.slave                 slave_if,
   output logic [REG_NUM*DATA_WIDTH-1:0] ctrl_reg_o,
   output logic [REG_NUM-1:0]            ctrl_wr_pulse_o,
   input  logic [4*DATA_WIDTH-1:0]       sta_reg_i,
   input  logic [DATA_WIDTH-1:0]         irq_src_i,
   output logic                          irq_o,
   output logic                          wdt_expire_o
);

   localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
   localparam int OFF_W = ADDR_WIDTH - 2;
   localparam logic [ADDR_WIDTH-1:0] ADDR_PEND = ADDR_WIDTH'(32'h200);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(32'h204);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ID   = ADDR_WIDTH'(32'h3FC);
   localparam logic [DATA_WIDTH-1:0] ID_VALUE  = DATA_WIDTH'(32'h5350_4901);
   localparam logic [DATA_WIDTH-1:0] UNMAPPED  = DATA_WIDTH'(32'hDEAD_BEEF);

   logic [DATA_WIDTH-1:0] ctrlReg_q [REG_NUM];
   logic [REG_NUM-1:0]    ctrlWrPulse_q;
   logic [DATA_WIDTH-1:0] irqPending_q, irqPending_d, irqMask_q, w1cData;
   logic                  irq_q;
   logic                  rdVld1_q, rdVld2_q;
   logic [DATA_WIDTH-1:0] rdWord_q, rdData_q, rdWord;
   logic                  wdtClear;

   logic [ADDR_WIDTH-1:0] off;
   logic [OFF_W-1:0]      wordIdx;
   logic [IDX_W-1:0]      ctrlSel;
   logic                  aligned, ctrlHit, staHit, pendHit, maskHit, idHit;

   // Offset arithmetic wraps modulo 2^ADDR_WIDTH; any misaligned offset is unmapped.
   assign off     = slave_if.slave_addr - BASE_ADDR;
   assign wordIdx = off[ADDR_WIDTH-1:2];
   assign ctrlSel = wordIdx[IDX_W-1:0];
   assign aligned = (off[1:0] == 2'b00);
   assign ctrlHit = aligned && (wordIdx < OFF_W'(REG_NUM));
   assign staHit  = aligned && (off[ADDR_WIDTH-1:4] == (ADDR_WIDTH-4)'(16));
   assign pendHit = (off == ADDR_PEND);
   assign maskHit = (off == ADDR_MASK);
   assign idHit   = (off == ADDR_ID);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < REG_NUM; k++) ctrlReg_q[k] <= '0;
         ctrlWrPulse_q <= '0;
      end else begin
         ctrlWrPulse_q <= '0;
         if (wdtClear) begin
            for (int k = 0; k < REG_NUM; k++) ctrlReg_q[k] <= '0;
         end else if (slave_if.slave_wr_en && ctrlHit) begin
            ctrlReg_q[ctrlSel]     <= slave_if.slave_wr_data;
            ctrlWrPulse_q[ctrlSel] <= 1'b1;
         end
      end
   end

   // A source that is active while its bit is being cleared keeps the bit set.
   assign w1cData      = (slave_if.slave_wr_en && pendHit) ? slave_if.slave_wr_data : '0;
   assign irqPending_d = (irqPending_q & ~w1cData) | irq_src_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irqPending_q <= '0;
         irqMask_q    <= '0;
         irq_q        <= 1'b0;
      end else begin
         irqPending_q <= irqPending_d;
         if (slave_if.slave_wr_en && maskHit) irqMask_q <= slave_if.slave_wr_data;
         irq_q <= |(irqPending_q & irqMask_q);
      end
   end

   always_comb begin
      rdWord = UNMAPPED;
      if (ctrlHit) begin
         rdWord = ctrlReg_q[ctrlSel];
      end else if (staHit) begin
         case (off[3:2])
            2'd0:    rdWord = sta_reg_i[0*DATA_WIDTH +: DATA_WIDTH];
            2'd1:    rdWord = sta_reg_i[1*DATA_WIDTH +: DATA_WIDTH];
            2'd2:    rdWord = sta_reg_i[2*DATA_WIDTH +: DATA_WIDTH];
            default: rdWord = sta_reg_i[3*DATA_WIDTH +: DATA_WIDTH];
         endcase
      end else if (pendHit) begin
         rdWord = irqPending_q;
      end else if (maskHit) begin
         rdWord = irqMask_q;
      end else if (idHit) begin
         rdWord = ID_VALUE;
      end
   end

   // Stage 1 captures pre-write register values, so a same-cycle write is not visible to the read.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdVld1_q <= 1'b0;
         rdVld2_q <= 1'b0;
         rdWord_q <= '0;
         rdData_q <= '0;
      end else begin
         rdVld1_q <= slave_if.slave_rd_en;
         rdVld2_q <= rdVld1_q;
         if (slave_if.slave_rd_en) rdWord_q <= rdWord;
         if (rdVld1_q) rdData_q <= rdWord_q;
      end
   end

`ifdef SPI_REG_WDT_EN
   localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

   logic [WDT_W-1:0] wdtCnt_q, wdtCnt_d;
   logic             wdtFired_q, wdtFired_d, wdtExpire_q;

   // The fired flag makes expiry one-shot until the driver touches the bank again.
   always_comb begin
      wdtCnt_d   = wdtCnt_q;
      wdtFired_d = wdtFired_q;
      wdtClear   = 1'b0;
      if (slave_if.slave_wr_en || slave_if.slave_rd_en) begin
         wdtCnt_d   = '0;
         wdtFired_d = 1'b0;
      end else if (wdtCnt_q == WDT_LAST) begin
         if (!wdtFired_q) begin
            wdtClear   = 1'b1;
            wdtFired_d = 1'b1;
         end
      end else begin
         wdtCnt_d = wdtCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wdtCnt_q    <= '0;
         wdtFired_q  <= 1'b0;
         wdtExpire_q <= 1'b0;
      end else begin
         wdtCnt_q    <= wdtCnt_d;
         wdtFired_q  <= wdtFired_d;
         wdtExpire_q <= wdtClear;
      end
   end

   assign wdt_expire_o = wdtExpire_q;
`else
   assign wdtClear     = 1'b0;
   assign wdt_expire_o = 1'b0;
`endif

   for (genvar k = 0; k < REG_NUM; k++) begin : g_ctrlOut
      assign ctrl_reg_o[k*DATA_WIDTH +: DATA_WIDTH] = ctrlReg_q[k];
   end

   assign ctrl_wr_pulse_o        = ctrlWrPulse_q;
   assign irq_o                  = irq_q;
   assign slave_if.slave_rd_vld  = rdVld2_q;
   assign slave_if.slave_rd_data = rdData_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank (REG_NUM=16, WDT_CYCLES=100).
// Watchdog expectations follow whether SPI_REG_WDT_EN is defined for the build.
module tb_spi_reg_bank;

`ifdef SPI_REG_WDT_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [511:0]  ctrlReg;
   logic [15:0]   ctrlWrPulse;
   logic [127:0]  staReg;
   logic [31:0]   irqSrc;
   logic          irq, wdtExpire;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   spi_reg_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) busIf ();

   spi_reg_bank #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .REG_NUM(16),
      .BASE_ADDR(16'h0000), .WDT_CYCLES(100)
   ) dut (
      .clk_i(clk), .rst_i(rst), .slave_if(busIf.slave),
      .ctrl_reg_o(ctrlReg), .ctrl_wr_pulse_o(ctrlWrPulse),
      .sta_reg_i(staReg), .irq_src_i(irqSrc),
      .irq_o(irq), .wdt_expire_o(wdtExpire)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doWrite(input logic [15:0] a, input logic [31:0] d);
      busIf.slave_wr_en   = 1'b1;
      busIf.slave_addr    = a;
      busIf.slave_wr_data = d;
      tick();
      busIf.slave_wr_en = 1'b0;
   endtask

   task automatic doRead(input logic [15:0] a, output logic v, output logic [31:0] d);
      busIf.slave_rd_en = 1'b1;
      busIf.slave_addr  = a;
      tick();
      busIf.slave_rd_en = 1'b0;
      tick();
      v = busIf.slave_rd_vld;
      d = busIf.slave_rd_data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      busIf.slave_wr_en = 1'b0; busIf.slave_rd_en = 1'b0;
      busIf.slave_addr = '0; busIf.slave_wr_data = '0;
      staReg = '0; irqSrc = '0;
      repeat (3) tick();
      total++; if (busIf.slave_rd_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld: got %b want 0", busIf.slave_rd_vld); end
      total++; if (busIf.slave_rd_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", busIf.slave_rd_data); end
      total++; if (ctrlReg !== 512'h0) begin bad++; $display("[TB] FAIL reset_ctrl: got %h want 0", ctrlReg); end
      total++; if ({ctrlWrPulse, irq, wdtExpire} !== 18'h0) begin bad++; $display("[TB] FAIL reset_misc: got %h want 0", {ctrlWrPulse, irq, wdtExpire}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_burst();
      doWrite(16'h008, 32'h1234_5678);
      total++; if (ctrlWrPulse !== 16'h0004) begin bad++; $display("[TB] FAIL wr_pulse: got %h want 0004", ctrlWrPulse); end
      total++; if (ctrlReg[2*32 +: 32] !== 32'h1234_5678) begin bad++; $display("[TB] FAIL wr_reg2: got %h want 12345678", ctrlReg[2*32 +: 32]); end
      busIf.slave_rd_en = 1'b1; busIf.slave_addr = 16'h004;
      tick();
      total++; if ({ctrlWrPulse, busIf.slave_rd_vld} !== 17'h0) begin bad++; $display("[TB] FAIL burst_n1: got %h want 0", {ctrlWrPulse, busIf.slave_rd_vld}); end
      busIf.slave_addr = 16'h008;
      tick();
      total++; if ({busIf.slave_rd_vld, busIf.slave_rd_data} !== {1'b1, 32'h0}) begin bad++; $display("[TB] FAIL burst_w0: got %h want 100000000", {busIf.slave_rd_vld, busIf.slave_rd_data}); end
      busIf.slave_addr = 16'h00C;
      tick();
      total++; if ({busIf.slave_rd_vld, busIf.slave_rd_data} !== {1'b1, 32'h1234_5678}) begin bad++; $display("[TB] FAIL burst_w1: got %h want 112345678", {busIf.slave_rd_vld, busIf.slave_rd_data}); end
      busIf.slave_rd_en = 1'b0;
      tick();
      total++; if ({busIf.slave_rd_vld, busIf.slave_rd_data} !== {1'b1, 32'h0}) begin bad++; $display("[TB] FAIL burst_w2: got %h want 100000000", {busIf.slave_rd_vld, busIf.slave_rd_data}); end
      tick();
      total++; if ({busIf.slave_rd_vld, ctrlWrPulse} !== 17'h0) begin bad++; $display("[TB] FAIL burst_end: got %h want 0", {busIf.slave_rd_vld, ctrlWrPulse}); end
   endtask

   task automatic test_collision();
      logic v; logic [31:0] d;
      busIf.slave_wr_en = 1'b1; busIf.slave_rd_en = 1'b1;
      busIf.slave_addr = 16'h00C; busIf.slave_wr_data = 32'hAAAA_0003;
      tick();
      busIf.slave_wr_en = 1'b0; busIf.slave_rd_en = 1'b0;
      total++; if ({ctrlWrPulse, ctrlReg[3*32 +: 32]} !== {16'h0008, 32'hAAAA_0003}) begin bad++; $display("[TB] FAIL coll_write: got %h want 0008aaaa0003", {ctrlWrPulse, ctrlReg[3*32 +: 32]}); end
      tick();
      total++; if ({busIf.slave_rd_vld, busIf.slave_rd_data} !== {1'b1, 32'h0}) begin bad++; $display("[TB] FAIL coll_preread: got %h want 100000000", {busIf.slave_rd_vld, busIf.slave_rd_data}); end
      doRead(16'h00C, v, d);
      total++; if ({v, d} !== {1'b1, 32'hAAAA_0003}) begin bad++; $display("[TB] FAIL coll_postread: got %h want 1aaaa0003", {v, d}); end
      doWrite(16'h03C, 32'hCAFE_0015);
      total++; if (ctrlWrPulse !== 16'h8000) begin bad++; $display("[TB] FAIL reg15_pulse: got %h want 8000", ctrlWrPulse); end
      doRead(16'h03C, v, d);
      total++; if ({v, d} !== {1'b1, 32'hCAFE_0015}) begin bad++; $display("[TB] FAIL reg15_read: got %h want 1cafe0015", {v, d}); end
      doRead(16'h040, v, d);
      total++; if ({v, d} !== {1'b1, 32'hDEAD_BEEF}) begin bad++; $display("[TB] FAIL reg16_read: got %h want 1deadbeef", {v, d}); end
   endtask

   task automatic test_status();
      logic v; logic [31:0] d; logic [511:0] expCtrl;
      expCtrl = '0;
      expCtrl[2*32 +: 32]  = 32'h1234_5678;
      expCtrl[3*32 +: 32]  = 32'hAAAA_0003;
      expCtrl[15*32 +: 32] = 32'hCAFE_0015;
      staReg = {32'h3333_0003, 32'h2222_0002, 32'hA5A5_0001, 32'h1111_0000};
      doRead(16'h104, v, d);
      total++; if ({v, d} !== {1'b1, 32'hA5A5_0001}) begin bad++; $display("[TB] FAIL sta1_read: got %h want 1a5a50001", {v, d}); end
      doWrite(16'h104, 32'hFFFF_FFFF);
      total++; if ({ctrlWrPulse, ctrlReg} !== {16'h0, expCtrl}) begin bad++; $display("[TB] FAIL sta_write_ignored: got %h want %h", {ctrlWrPulse, ctrlReg}, {16'h0, expCtrl}); end
      doRead(16'h104, v, d);
      total++; if ({v, d} !== {1'b1, 32'hA5A5_0001}) begin bad++; $display("[TB] FAIL sta1_reread: got %h want 1a5a50001", {v, d}); end
      doRead(16'h10C, v, d);
      total++; if ({v, d} !== {1'b1, 32'h3333_0003}) begin bad++; $display("[TB] FAIL sta3_read: got %h want 133330003", {v, d}); end
      doRead(16'h3FC, v, d);
      total++; if ({v, d} !== {1'b1, 32'h5350_4901}) begin bad++; $display("[TB] FAIL id_read: got %h want 153504901", {v, d}); end
      tick();
      total++; if ({busIf.slave_rd_vld, busIf.slave_rd_data} !== {1'b0, 32'h5350_4901}) begin bad++; $display("[TB] FAIL rdata_hold: got %h want 053504901", {busIf.slave_rd_vld, busIf.slave_rd_data}); end
      doRead(16'h002, v, d);
      total++; if ({v, d} !== {1'b1, 32'hDEAD_BEEF}) begin bad++; $display("[TB] FAIL misaligned_read: got %h want 1deadbeef", {v, d}); end
      doRead(16'h500, v, d);
      total++; if ({v, d} !== {1'b1, 32'hDEAD_BEEF}) begin bad++; $display("[TB] FAIL unmapped_read: got %h want 1deadbeef", {v, d}); end
   endtask

   task automatic test_irq();
      logic v; logic [31:0] d;
      doWrite(16'h204, 32'h8);
      doRead(16'h204, v, d);
      total++; if ({v, d} !== {1'b1, 32'h8}) begin bad++; $display("[TB] FAIL mask_read: got %h want 100000008", {v, d}); end
      irqSrc = 32'h1; tick(); irqSrc = 32'h0; tick(); tick();
      total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_masked: got %b want 0", irq); end
      doRead(16'h200, v, d);
      total++; if ({v, d} !== {1'b1, 32'h1}) begin bad++; $display("[TB] FAIL pend_masked: got %h want 100000001", {v, d}); end
      doWrite(16'h200, 32'h1);
      doRead(16'h200, v, d);
      total++; if ({v, d} !== {1'b1, 32'h0}) begin bad++; $display("[TB] FAIL pend_clr1: got %h want 100000000", {v, d}); end
      irqSrc = 32'h8; tick(); irqSrc = 32'h0;
      total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_rise_early: got %b want 0", irq); end
      tick();
      total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_rise: got %b want 1", irq); end
      doRead(16'h200, v, d);
      total++; if ({v, d} !== {1'b1, 32'h8}) begin bad++; $display("[TB] FAIL pend_read: got %h want 100000008", {v, d}); end
      doRead(16'h200, v, d);
      total++; if ({v, d} !== {1'b1, 32'h8}) begin bad++; $display("[TB] FAIL pend_reread: got %h want 100000008", {v, d}); end
      doWrite(16'h200, 32'h8);
      total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_fall_early: got %b want 1", irq); end
      tick();
      total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_fall: got %b want 0", irq); end
      busIf.slave_wr_en = 1'b1; busIf.slave_addr = 16'h200; busIf.slave_wr_data = 32'h8; irqSrc = 32'h8;
      tick();
      busIf.slave_wr_en = 1'b0; irqSrc = 32'h0;
      tick();
      doRead(16'h200, v, d);
      total++; if ({v, d, irq} !== {1'b1, 32'h8, 1'b1}) begin bad++; $display("[TB] FAIL set_wins: got %h want 200000011", {v, d, irq}); end
   endtask

   task automatic test_reset_mid_burst();
      logic v; logic [31:0] d; int vldCount;
      busIf.slave_rd_en = 1'b1; busIf.slave_addr = 16'h008;
      tick();
      busIf.slave_addr = 16'h00C;
      tick();
      total++; if ({busIf.slave_rd_vld, busIf.slave_rd_data} !== {1'b1, 32'h1234_5678}) begin bad++; $display("[TB] FAIL mid_first_vld: got %h want 112345678", {busIf.slave_rd_vld, busIf.slave_rd_data}); end
      busIf.slave_addr = 16'h010;
      #2 rst = 1'b1;
      #1;
      total++; if ({busIf.slave_rd_vld, busIf.slave_rd_data, ctrlWrPulse, irq, wdtExpire} !== 51'h0) begin bad++; $display("[TB] FAIL mid_outs: got %h want 0", {busIf.slave_rd_vld, busIf.slave_rd_data, ctrlWrPulse, irq, wdtExpire}); end
      total++; if (ctrlReg !== 512'h0) begin bad++; $display("[TB] FAIL mid_ctrl: got %h want 0", ctrlReg); end
      busIf.slave_rd_en = 1'b0;
      tick(); tick();
      rst = 1'b0;
      vldCount = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (busIf.slave_rd_vld === 1'b1) vldCount++;
      end
      total++; if (vldCount !== 0) begin bad++; $display("[TB] FAIL mid_no_vld: got %0d want 0", vldCount); end
      doRead(16'h000, v, d);
      total++; if ({v, d} !== {1'b1, 32'h0}) begin bad++; $display("[TB] FAIL post_rst_read: got %h want 100000000", {v, d}); end
      doRead(16'h200, v, d);
      total++; if ({v, d} !== {1'b1, 32'h0}) begin bad++; $display("[TB] FAIL post_rst_pend: got %h want 100000000", {v, d}); end
   endtask

   task automatic test_watchdog();
      logic v; logic [31:0] d; int early; int pulses;
      logic [31:0] expReg0;
      expReg0 = WDT_ON ? 32'h0 : 32'h5;
      doWrite(16'h204, 32'h8);
      doWrite(16'h000, 32'h5);
      early = 0;
      for (int k = 1; k < 100; k++) begin
         tick();
         if (wdtExpire !== 1'b0 || ctrlReg[31:0] !== 32'h5) early++;
      end
      total++; if (early !== 0) begin bad++; $display("[TB] FAIL wdt_early: got %0d events want 0", early); end
      tick();
      total++; if ({wdtExpire, ctrlReg[31:0], ctrlWrPulse} !== {WDT_ON, expReg0, 16'h0}) begin bad++; $display("[TB] FAIL wdt_expire: got %h want %h", {wdtExpire, ctrlReg[31:0], ctrlWrPulse}, {WDT_ON, expReg0, 16'h0}); end
      tick();
      total++; if (wdtExpire !== 1'b0) begin bad++; $display("[TB] FAIL wdt_one_cycle: got %b want 0", wdtExpire); end
      pulses = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (wdtExpire === 1'b1) pulses++;
      end
      total++; if ({pulses, ctrlReg[31:0]} !== {32'd0, expReg0}) begin bad++; $display("[TB] FAIL wdt_oneshot: got pulses=%0d reg0=%h want pulses=0 reg0=%h", pulses, ctrlReg[31:0], expReg0); end
      doRead(16'h204, v, d);
      total++; if ({v, d} !== {1'b1, 32'h8}) begin bad++; $display("[TB] FAIL wdt_mask_kept: got %h want 100000008", {v, d}); end
      doWrite(16'h000, 32'h5);
      pulses = 0;
      busIf.slave_addr = 16'h000;
      for (int i = 0; i < 300; i++) begin
         busIf.slave_rd_en = ((i % 50) == 49);
         tick();
         if (wdtExpire === 1'b1) pulses++;
      end
      busIf.slave_rd_en = 1'b0;
      total++; if ({pulses, ctrlReg[31:0]} !== {32'd0, 32'h5}) begin bad++; $display("[TB] FAIL wdt_kept_alive: got pulses=%0d reg0=%h want pulses=0 reg0=5", pulses, ctrlReg[31:0]); end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_collision();
      test_status();
      test_irq();
      test_reset_mid_burst();
      test_watchdog();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
